// File: rtl/icache_pkg.sv
// Shared widths, default geometry, FSM encoding and small helpers for the icache slice.
// The optional ICACHE_STATS_EN build adds hit/miss counters to the top.
package icache_pkg;

  localparam int DATA_WIDTH         = 32;
  localparam int DEFAULT_INDEX_BITS = 7;
  localparam int DEFAULT_ADDR_BITS  = 18;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MISS = 1'b1
  } icache_state_e;

  // Memory requests are always word aligned, whatever the fetcher put in [1:0].
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/icache_if.sv
// Fetcher-side and memory-side handshake of the instruction cache.
// master = fetcher/memory environment, slave = the cache itself.
interface icache_if;
  import icache_pkg::*;

  logic                  in_fetcher_ena;
  logic [31:0]           in_fetcher_addr;
  logic                  out_fetcher_ok;
  logic [DATA_WIDTH-1:0] out_fetcher_data;
  logic                  out_mem_ena;
  logic [31:0]           out_mem_addr;
  logic                  in_mem_ok;
  logic [DATA_WIDTH-1:0] in_mem_data;

  modport master (
    output in_fetcher_ena, in_fetcher_addr, in_mem_ok, in_mem_data,
    input  out_fetcher_ok, out_fetcher_data, out_mem_ena, out_mem_addr
  );

  modport slave (
    input  in_fetcher_ena, in_fetcher_addr, in_mem_ok, in_mem_data,
    output out_fetcher_ok, out_fetcher_data, out_mem_ena, out_mem_addr
  );

endinterface

// File: rtl/icache_store.sv
// Direct-mapped valid/tag/data storage: combinational lookup, one write port.
// Valid bits are the only state cleared by reset.
module icache_store
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = DEFAULT_INDEX_BITS,
  parameter int TAG_BITS   = DEFAULT_ADDR_BITS - 2 - DEFAULT_INDEX_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] lookup_index,
  input  logic [TAG_BITS-1:0]   lookup_tag,
  output logic                  hit,
  output logic [DATA_WIDTH-1:0] hit_data,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [DATA_WIDTH-1:0] wr_data
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]      valid_r;
  logic [TAG_BITS-1:0]   tag_r  [LINES];
  logic [DATA_WIDTH-1:0] data_r [LINES];

  // Valid vector: cleared on reset, set only for the line being filled.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= '0;
    end else if (we) begin
      valid_r[wr_index] <= 1'b1;
    end
  end

  // Tag and data payload; no reset needed since valid gates every use.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_r[wr_index]  <= wr_tag;
      data_r[wr_index] <= wr_data;
    end
  end

  assign hit      = valid_r[lookup_index] && (tag_r[lookup_index] == lookup_tag);
  assign hit_data = data_r[lookup_index];

endmodule

// File: rtl/icache.sv
// Direct-mapped one-word-per-line instruction cache: IDLE/MISS controller and handshakes.
// Define ICACHE_STATS_EN to add saturating hit/miss counter outputs.
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = DEFAULT_INDEX_BITS,
  parameter int ADDR_BITS  = DEFAULT_ADDR_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic        in_rollback,
  icache_if.slave     bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] out_hit_count,
  output logic [31:0] out_miss_count
`endif
);

  localparam int TAG_BITS = ADDR_BITS - 2 - INDEX_BITS;

  icache_state_e         state_r, state_s;
  logic                  ok_r, ok_s;
  logic [DATA_WIDTH-1:0] data_r, data_s;
  logic                  mem_ena_r, mem_ena_s;
  logic [31:0]           mem_addr_r, mem_addr_s;

  logic                  hit_s;
  logic [DATA_WIDTH-1:0] hit_data_s;
  logic                  fill_s;
  logic                  sample_hit_s;
  logic                  start_miss_s;
  logic                  we_s;
  logic [INDEX_BITS-1:0] req_index_s;
  logic [TAG_BITS-1:0]   req_tag_s;
  logic [INDEX_BITS-1:0] fill_index_s;
  logic [TAG_BITS-1:0]   fill_tag_s;
  logic                  unused_bits_s;

  assign req_index_s  = bus.in_fetcher_addr[INDEX_BITS+1:2];
  assign req_tag_s    = bus.in_fetcher_addr[ADDR_BITS-1:INDEX_BITS+2];
  // The latched miss address drives both the memory request and the fill location.
  assign fill_index_s = mem_addr_r[INDEX_BITS+1:2];
  assign fill_tag_s   = mem_addr_r[ADDR_BITS-1:INDEX_BITS+2];
  assign we_s         = fill_s && ena && !rst;

  assign unused_bits_s = ^{bus.in_fetcher_addr[31:ADDR_BITS], bus.in_fetcher_addr[1:0],
                           mem_addr_r[31:ADDR_BITS], mem_addr_r[1:0]};

  icache_store #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_store (
    .clk          (clk),
    .rst          (rst),
    .lookup_index (req_index_s),
    .lookup_tag   (req_tag_s),
    .hit          (hit_s),
    .hit_data     (hit_data_s),
    .we           (we_s),
    .wr_index     (fill_index_s),
    .wr_tag       (fill_tag_s),
    .wr_data      (bus.in_mem_data)
  );

  // Next-state and next-output logic; rollback overrides everything but reset.
  always_comb begin
    state_s      = state_r;
    ok_s         = 1'b0;
    data_s       = data_r;
    mem_ena_s    = mem_ena_r;
    mem_addr_s   = mem_addr_r;
    fill_s       = 1'b0;
    sample_hit_s = 1'b0;
    start_miss_s = 1'b0;
    if (in_rollback) begin
      state_s   = ST_IDLE;
      mem_ena_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.in_fetcher_ena) begin
            if (hit_s) begin
              sample_hit_s = 1'b1;
              ok_s         = 1'b1;
              data_s       = hit_data_s;
            end else begin
              start_miss_s = 1'b1;
              state_s      = ST_MISS;
              mem_ena_s    = 1'b1;
              mem_addr_s   = word_align(bus.in_fetcher_addr);
            end
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_MISS: begin
          if (bus.in_mem_ok) begin
            fill_s    = 1'b1;
            state_s   = ST_IDLE;
            mem_ena_s = 1'b0;
            ok_s      = 1'b1;
            data_s    = bus.in_mem_data;
          end else begin
            state_s = ST_MISS;
          end
        end
        default: begin
          state_s   = ST_IDLE;
          mem_ena_s = 1'b0;
        end
      endcase
    end
  end

  // State and registered outputs; ena low freezes everything, including a pending ok.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      ok_r       <= 1'b0;
      data_r     <= '0;
      mem_ena_r  <= 1'b0;
      mem_addr_r <= 32'h0000_0000;
    end else if (ena) begin
      state_r    <= state_s;
      ok_r       <= ok_s;
      data_r     <= data_s;
      mem_ena_r  <= mem_ena_s;
      mem_addr_r <= mem_addr_s;
    end
  end

  assign bus.out_fetcher_ok   = ok_r;
  assign bus.out_fetcher_data = data_r;
  assign bus.out_mem_ena      = mem_ena_r;
  assign bus.out_mem_addr     = mem_addr_r;

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count_r;
  logic [31:0] miss_count_r;

  // Saturating counters; a miss counts at IDLE->MISS even if later rolled back.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count_r  <= 32'd0;
      miss_count_r <= 32'd0;
    end else if (ena) begin
      if (sample_hit_s) begin
        hit_count_r <= sat_inc(hit_count_r);
      end
      if (start_miss_s) begin
        miss_count_r <= sat_inc(miss_count_r);
      end
    end
  end

  assign out_hit_count  = hit_count_r;
  assign out_miss_count = miss_count_r;
`else
  logic unused_stats_s;
  assign unused_stats_s = sample_hit_s ^ start_miss_s;
`endif

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: a line-level cache model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_icache;

  logic clk = 1'b0;
  logic rst;
  logic ena;
  logic in_rollback;

  icache_if bus ();

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  icache dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .in_rollback (in_rollback),
    .bus         (bus)
`ifdef ICACHE_STATS_EN
    ,
    .out_hit_count  (hit_count),
    .out_miss_count (miss_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Lines keyed by index (addr/4 mod 128), holding tag (addr/512 mod 512) and word.
  int unsigned line_tag  [int];
  logic [31:0] line_word [int];
  bit          live = 1'b0;
  bit          waiting;            // a miss is outstanding at memory
  logic [31:0] wait_addr;
  logic        e_ok, e_mena;
  logic [31:0] e_data, e_maddr;
  int unsigned m_hits, m_misses;

  always @(posedge clk) begin
    int unsigned a, idx, tg;
    if (rst) begin
      line_tag.delete();
      line_word.delete();
      waiting = 1'b0; wait_addr = 32'd0;
      e_ok = 1'b0; e_data = 32'd0; e_mena = 1'b0; e_maddr = 32'd0;
      m_hits = 0; m_misses = 0;
      live = 1'b1;
    end else if (ena) begin
      e_ok = 1'b0;
      if (in_rollback) begin
        waiting = 1'b0;
        e_mena  = 1'b0;
      end else if (waiting) begin
        if (bus.in_mem_ok) begin
          a   = wait_addr;
          idx = (a / 4) % 128;
          line_tag[idx]  = (a / 512) % 512;
          line_word[idx] = bus.in_mem_data;
          e_ok = 1'b1; e_data = bus.in_mem_data;
          waiting = 1'b0; e_mena = 1'b0;
        end
      end else if (bus.in_fetcher_ena) begin
        a   = bus.in_fetcher_addr;
        idx = (a / 4) % 128;
        tg  = (a / 512) % 512;
        if (line_tag.exists(idx) && line_tag[idx] == tg) begin
          e_ok = 1'b1; e_data = line_word[idx];
          m_hits++;
        end else begin
          waiting   = 1'b1;
          wait_addr = a & 32'hFFFF_FFFC;
          e_mena = 1'b1; e_maddr = wait_addr;
          m_misses++;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (live && !rst) begin
      chk("cyc_ok",       {31'd0, bus.out_fetcher_ok}, {31'd0, e_ok});
      chk("cyc_data",     bus.out_fetcher_data, e_data);
      chk("cyc_mem_ena",  {31'd0, bus.out_mem_ena}, {31'd0, e_mena});
      chk("cyc_mem_addr", bus.out_mem_addr, e_maddr);
`ifdef ICACHE_STATS_EN
      chk("cyc_hit_count",  hit_count,  m_hits);
      chk("cyc_miss_count", miss_count, m_misses);
`endif
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Miss at addr; memory answers so that in_mem_ok is sampled lat edges after the request.
  task automatic do_miss(input string tag, input logic [31:0] addr, input int lat,
                         input logic [31:0] word);
    int ena_cycles = 0;
    bus.in_fetcher_ena = 1'b1; bus.in_fetcher_addr = addr;
    tick();
    bus.in_fetcher_ena = 1'b0;
    chk({tag, "_mem_addr"}, bus.out_mem_addr, {addr[31:2], 2'b00});
    for (int i = 0; i < lat; i++) begin
      if (bus.out_mem_ena) ena_cycles++;
      chk({tag, "_no_ok_during_miss"}, {31'd0, bus.out_fetcher_ok}, 32'd0);
      if (i < lat - 1) tick();
    end
    bus.in_mem_ok = 1'b1; bus.in_mem_data = word;
    tick();
    bus.in_mem_ok = 1'b0;
    chk({tag, "_mem_ena_cycles"}, ena_cycles, lat);
    chk({tag, "_fill_ok"},   {31'd0, bus.out_fetcher_ok}, 32'd1);
    chk({tag, "_fill_data"}, bus.out_fetcher_data, word);
    chk({tag, "_mem_ena_drop"}, {31'd0, bus.out_mem_ena}, 32'd0);
    tick();
    chk({tag, "_ok_one_cycle"}, {31'd0, bus.out_fetcher_ok}, 32'd0);
  endtask

  task automatic do_hit(input string tag, input logic [31:0] addr, input logic [31:0] word);
    bus.in_fetcher_ena = 1'b1; bus.in_fetcher_addr = addr;
    tick();
    bus.in_fetcher_ena = 1'b0;
    chk({tag, "_ok"},      {31'd0, bus.out_fetcher_ok}, 32'd1);
    chk({tag, "_data"},    bus.out_fetcher_data, word);
    chk({tag, "_no_mem"},  {31'd0, bus.out_mem_ena}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1; in_rollback = 1'b0;
    bus.in_fetcher_ena = 1'b0; bus.in_fetcher_addr = 32'd0;
    bus.in_mem_ok = 1'b0; bus.in_mem_data = 32'd0;
    tick(); tick();
    rst = 1'b0;
    chk("reset_ok",       {31'd0, bus.out_fetcher_ok}, 32'd0);
    chk("reset_data",     bus.out_fetcher_data, 32'd0);
    chk("reset_mem_ena",  {31'd0, bus.out_mem_ena}, 32'd0);
    chk("reset_mem_addr", bus.out_mem_addr, 32'd0);
    tick();

    // Cold fetch, memory latency 4.
    do_miss("cold0", 32'h0000_0000, 4, 32'h0000_0413);

    // Refetch hits; the next word misses.
    do_hit("refetch0", 32'h0000_0000, 32'h0000_0413);
    tick();
    do_miss("cold4", 32'h0000_0004, 2, 32'h0000_0513);

    // Address bits above ADDR_BITS do not take part in the tag.
    do_hit("high_bits", 32'hFFFC_0000, 32'h0000_0413);
    tick();

    // Conflict on index 4.
    do_miss("fill10",  32'h0000_0010, 1, 32'hAAAA_0010);
    do_miss("fill210", 32'h0000_0210, 3, 32'hBBBB_0210);
    do_miss("refill10", 32'h0000_0010, 2, 32'hCCCC_0010);

    // Rollback coincident with in_mem_ok: no fill, no ok.
    bus.in_fetcher_ena = 1'b1; bus.in_fetcher_addr = 32'h0000_0100;
    tick();
    bus.in_fetcher_ena = 1'b0;
    chk("rb_mem_ena", {31'd0, bus.out_mem_ena}, 32'd1);
    tick();
    in_rollback = 1'b1; bus.in_mem_ok = 1'b1; bus.in_mem_data = 32'hDEAD_BEEF;
    tick();
    in_rollback = 1'b0; bus.in_mem_ok = 1'b0;
    chk("rb_no_ok",      {31'd0, bus.out_fetcher_ok}, 32'd0);
    chk("rb_mem_ena_off", {31'd0, bus.out_mem_ena}, 32'd0);
    tick();
    chk("rb_no_ok_late", {31'd0, bus.out_fetcher_ok}, 32'd0);
    do_miss("rb_refetch", 32'h0000_0100, 2, 32'h1111_2222);
    // Line 0 survived the rollback.
    do_hit("rb_keep0", 32'h0000_0000, 32'h0000_0413);

    // Freeze with ok pending.
    ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("freeze_ok",   {31'd0, bus.out_fetcher_ok}, 32'd1);
      chk("freeze_data", bus.out_fetcher_data, 32'h0000_0413);
    end
    ena = 1'b1;
    tick();
    chk("release_ok_drop", {31'd0, bus.out_fetcher_ok}, 32'd0);

    // Back-to-back hits, one per cycle.
    do_miss("fill8", 32'h0000_0008, 1, 32'h0000_0613);
    begin
`ifdef ICACHE_STATS_EN
      logic [31:0] hits_before;
      hits_before = hit_count;
`endif
      bus.in_fetcher_ena = 1'b1;
      bus.in_fetcher_addr = 32'h0000_0000; tick();
      chk("b2b0_ok", {31'd0, bus.out_fetcher_ok}, 32'd1);
      chk("b2b0_data", bus.out_fetcher_data, 32'h0000_0413);
      bus.in_fetcher_addr = 32'h0000_0004; tick();
      chk("b2b1_ok", {31'd0, bus.out_fetcher_ok}, 32'd1);
      chk("b2b1_data", bus.out_fetcher_data, 32'h0000_0513);
      bus.in_fetcher_addr = 32'h0000_0008; tick();
      chk("b2b2_ok", {31'd0, bus.out_fetcher_ok}, 32'd1);
      chk("b2b2_data", bus.out_fetcher_data, 32'h0000_0613);
      bus.in_fetcher_ena = 1'b0; tick();
      chk("b2b_end_ok", {31'd0, bus.out_fetcher_ok}, 32'd0);
`ifdef ICACHE_STATS_EN
      chk("b2b_hit_delta", hit_count - hits_before, 32'd3);
`endif
    end

    // Reset invalidates every line.
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst2_ok", {31'd0, bus.out_fetcher_ok}, 32'd0);
    do_miss("post_rst0", 32'h0000_0000, 1, 32'h0000_0713);

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, time %0t, limit 200000", $time);
    $fatal(1);
  end

endmodule
